// File: rtl/bcxtreme_result_collector_pkg.sv
// Shared types for the result collector.
//   state_e  : collector FSM states
//   result_t : registered result payload {found, nonce, block}
package bcxtreme_result_collector_pkg;
   localparam int NONCE_W = 32;
   localparam int BLOCK_W = 8;   // width of the block tag carried in result_t

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_HOLD,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic               found;
      logic [NONCE_W-1:0] nonce;
      logic [BLOCK_W-1:0] block;
   } result_t;
endpackage

// File: rtl/bcxtreme_nonce_tracker.sv
// Tracks the nonce offset within the current block and the block sequence id.
//   clk, rst       : clock, async active-high reset
//   valid_i        : one nonce step completed this cycle
//   newblock_i     : this step is offset 0 of a new block
//   cur_off_o      : offset of the step being presented this cycle
//   cur_block_o    : block id of the step being presented this cycle
//   last_o         : presented step is the last offset of the block
module bcxtreme_nonce_tracker #(
   parameter int OFFW        = 31,
   parameter int BLOCKIDBITS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   input  logic                   newblock_i,
   output logic [OFFW-1:0]        cur_off_o,
   output logic [BLOCKIDBITS-1:0] cur_block_o,
   output logic                   last_o
);
   logic [OFFW-1:0]        off_q;
   logic [BLOCKIDBITS-1:0] blk_q;
   logic                   nb;

   assign nb = valid_i & newblock_i;

   // The register holds the offset of the *next* step; a newblock step
   // overrides it with 0 combinationally so it is evaluated at offset 0.
   assign cur_off_o   = nb ? '0 : off_q;
   assign cur_block_o = nb ? blk_q + 1'b1 : blk_q;
   assign last_o      = &cur_off_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q <= '0;
         blk_q <= '0;
      end else if (valid_i) begin
         off_q <= cur_off_o + 1'b1;
         blk_q <= cur_block_o;
      end
   end
endmodule

// File: rtl/bcxtreme_result_collector.sv
// Chain terminus: rebuilds the winning nonce and presents one result per
// block (found or exhausted) over a valid/ready handshake.
//   clk, rst       : clock, async active-high reset
//   valid_i        : chain-wide nonce step completed
//   newblock_i     : step is offset 0 of a new block
//   victory_i      : chain-wide success for this step
//   nonce_start_i  : partition index of the winning processor
//   result_valid/result_ready : result handshake
//   result_found   : 1 = winning nonce, 0 = block exhausted
//   result_nonce   : winning nonce ({offset, nonce_start}), 0 if exhausted
//   result_block   : block sequence tag
//   missed_count   : saturating count of victories dropped during HOLD
module bcxtreme_result_collector
   import bcxtreme_result_collector_pkg::*;
#(
   parameter int PARTITIONBITS = 1,
   parameter int BLOCKIDBITS   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic                     newblock_i,
   input  logic                     victory_i,
   input  logic [PARTITIONBITS-1:0] nonce_start_i,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic                     result_found,
   output logic [NONCE_W-1:0]       result_nonce,
   output logic [BLOCKIDBITS-1:0]   result_block,
   output logic [7:0]               missed_count
);
   localparam int OFFW = NONCE_W - PARTITIONBITS;

   state_e  state_q, state_d;
   result_t res_q, res_d;
   logic    vld_q, vld_d;
   logic    pend_q, pend_d;
   logic [7:0] miss_q, miss_d;

   logic [OFFW-1:0]        cur_off;
   logic [BLOCKIDBITS-1:0] cur_blk;
   logic                   last;
   logic                   nb, win, do_eval;

   bcxtreme_nonce_tracker #(
      .OFFW        (OFFW),
      .BLOCKIDBITS (BLOCKIDBITS)
   ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .newblock_i  (newblock_i),
      .cur_off_o   (cur_off),
      .cur_block_o (cur_blk),
      .last_o      (last)
   );

   assign nb  = valid_i & newblock_i;
   assign win = valid_i & victory_i;

   // A step is evaluated in SEARCH, or in IDLE/DONE when it opens a block.
   assign do_eval = (state_q == ST_SEARCH && valid_i) ||
                    ((state_q == ST_IDLE || state_q == ST_DONE) && nb);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      vld_d   = vld_q;
      pend_d  = pend_q;
      miss_d  = miss_q;

      if (do_eval) begin
         state_d = ST_SEARCH;
         // Victory outranks exhaustion on the last step.
         if (win) begin
            res_d   = '{found: 1'b1, nonce: {cur_off, nonce_start_i}, block: cur_blk};
            vld_d   = 1'b1;
            state_d = ST_HOLD;
         end else if (last) begin
            res_d   = '{found: 1'b0, nonce: '0, block: cur_blk};
            vld_d   = 1'b1;
            state_d = ST_HOLD;
         end
      end

      if (state_q == ST_HOLD) begin
         if (win && miss_q != 8'hFF) miss_d = miss_q + 8'd1;
         if (nb) pend_d = 1'b1;
         if (result_ready) begin
            vld_d   = 1'b0;
            pend_d  = 1'b0;
            // A block opened on the accept cycle itself still counts as pending.
            state_d = (pend_q || nb) ? ST_SEARCH : ST_DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         vld_q   <= 1'b0;
         pend_q  <= 1'b0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         pend_q  <= pend_d;
         miss_q  <= miss_d;
      end
   end

   assign result_valid = vld_q;
   assign result_found = res_q.found;
   assign result_nonce = res_q.nonce;
   assign result_block = res_q.block;
   assign missed_count = miss_q;
endmodule

// File: tb/tb_bcxtreme_result_collector.sv
module tb_bcxtreme_result_collector;
   localparam int PB   = 24;          // offset is 8 bits so a block can be exhausted
   localparam int OFFW = 32 - PB;
   localparam int OFFMAX = (1 << OFFW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0, newblock_i = 1'b0, victory_i = 1'b0;
   logic [PB-1:0] nonce_start_i = '0;
   logic          result_ready = 1'b0;
   logic          result_valid, result_found;
   logic [31:0]   result_nonce;
   logic [7:0]    result_block, missed_count;

   int checks = 0;
   int errors = 0;

   // reference model (block-level view)
   bit       m_search, m_pend, m_valid, m_found;
   int       m_off, m_blk, m_missed, m_block;
   bit [31:0] m_nonce;

   bcxtreme_result_collector #(.PARTITIONBITS(PB), .BLOCKIDBITS(8)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i),
      .victory_i(victory_i), .nonce_start_i(nonce_start_i),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_found(result_found), .result_nonce(result_nonce),
      .result_block(result_block), .missed_count(missed_count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("valid",  32'(result_valid), 32'(m_valid));
      chk("found",  32'(result_found), 32'(m_found));
      chk("nonce",  result_nonce, m_nonce);
      chk("block",  32'(result_block), 32'(m_block));
      chk("missed", 32'(missed_count), 32'(m_missed));
   endtask

   function automatic void model_reset();
      m_search = 0; m_pend = 0; m_valid = 0; m_found = 0;
      m_off = 0; m_blk = 0; m_missed = 0; m_block = 0; m_nonce = 0;
   endfunction

   // One clock edge of the reference: blocks are searched step by step, a
   // result is parked until the host takes it, and late victories are tallied.
   function automatic void model_edge(bit v, bit n, bit vic, int ns, bit rdy);
      bit nbs = v && n;
      int co  = nbs ? 0 : m_off;
      int cb  = nbs ? (m_blk + 1) % 256 : m_blk;
      if (m_valid) begin
         if (v && vic && m_missed < 255) m_missed++;
         if (nbs) m_pend = 1;
         if (rdy) begin
            m_valid = 0; m_search = m_pend; m_pend = 0;
         end
      end else if (v && (m_search || nbs)) begin
         m_search = 1;
         if (vic) begin
            m_valid = 1; m_found = 1; m_nonce = (32'(co) << PB) | 32'(ns);
            m_block = cb; m_search = 0;
         end else if (co == OFFMAX) begin
            m_valid = 1; m_found = 0; m_nonce = 0; m_block = cb; m_search = 0;
         end
      end
      if (v) begin
         m_off = (co + 1) % (OFFMAX + 1);
         m_blk = cb;
      end
   endfunction

   task automatic step(input bit v, input bit n, input bit vic, input int ns, input bit rdy);
      @(negedge clk);
      valid_i = v; newblock_i = n; victory_i = vic;
      nonce_start_i = ns[PB-1:0]; result_ready = rdy;
      @(posedge clk);
      model_edge(v, n, vic, ns, rdy);
      #1 check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // newblock, victory at offset 5 with nonce_start 1
      step(1, 1, 0, 0, 0);
      for (int i = 1; i < 5; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 0);
      chk("t1_nonce", result_nonce, 32'h0500_0001);
      chk("t1_block", 32'(result_block), 32'd1);

      // hold 10 cycles with 3 dropped victories, payload stable
      for (int i = 0; i < 10; i++) step(1, 0, (i % 3 == 0 && i < 9), 9, 0);
      chk("t2_missed", 32'(missed_count), 32'd3);
      chk("t2_nonce",  result_nonce, 32'h0500_0001);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 1);
      chk("t2_done", 32'(result_valid), 32'd0);

      // exhaustion without victory
      step(1, 1, 0, 0, 1);
      for (int i = 1; i <= OFFMAX; i++) step(1, 0, 0, 0, 0);
      chk("t3_found", 32'(result_found), 32'd0);
      chk("t3_nonce", result_nonce, 32'd0);
      chk("t3_valid", 32'(result_valid), 32'd1);
      step(0, 0, 0, 0, 1);
      // victory on the last step
      step(1, 1, 0, 0, 0);
      for (int i = 1; i < OFFMAX; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 24'h123456, 0);
      chk("t3_vnonce", result_nonce, 32'hFF12_3456);
      chk("t3_vfound", 32'(result_found), 32'd1);
      step(0, 0, 0, 0, 1);

      // newblock during HOLD, accept 4 cycles later
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 7, 0);
      chk("t4_first", 32'(result_block), 32'd4);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 5, 0);
      chk("t4_block", 32'(result_block), 32'd5);
      chk("t4_nonce", result_nonce, 32'h0400_0005);
      step(0, 0, 0, 0, 1);

      // victory together with newblock, nonce_start 0
      step(1, 1, 1, 0, 0);
      chk("t5_nonce", result_nonce, 32'd0);
      chk("t5_found", 32'(result_found), 32'd1);
      chk("t5_block", 32'(result_block), 32'd6);
      step(0, 0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3,
                   $urandom_range(0, 99) < 6, int'($urandom) & 32'h00FF_FFFF,
                   $urandom_range(0, 1) == 1);
      end

      // reset while holding a result, then victory with no block open
      step(0, 0, 0, 0, 1);
      step(1, 1, 1, 42, 0);
      chk("t6_hold", 32'(result_valid), 32'd1);
      @(negedge clk);
      valid_i = 0; newblock_i = 0; victory_i = 0;
      #2 rst = 1'b1;
      #1 model_reset();
      chk("t6_rst_valid", 32'(result_valid), 32'd0);
      chk("t6_rst_nonce", result_nonce, 32'd0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, 1, 11, 0);
      step(1, 0, 1, 12, 0);
      chk("t6_ignored", 32'(result_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
